// File: rtl/xc20xx_cfg_loader.sv
// Serial configuration bitstream loader: preamble lock, 24-bit length field, framed data with start/stop bits.
// Optional macro XC20XX_CFG_STOPCHK_EN makes every length/frame stop bit a checked 1 (a 0 traps in ERR).
module xc20xx_cfg_loader #(
    parameter int FRAME_BITS = 46,
    parameter int NUM_FRAMES = 160,
    parameter int FA_W       = 8
) (
    input  logic                  K,
    input  logic                  RST_N,
    input  logic                  DIN,
    input  logic                  DIN_VALID,
    output logic [FRAME_BITS-1:0] FRAME_DATA,
    output logic [FA_W-1:0]       FRAME_ADDR,
    output logic                  FRAME_VALID,
    output logic [23:0]           LEN_COUNT,
    output logic                  DONE,
    output logic                  ERROR,
    output logic [3:0]            STATE_DBG
);

    localparam int LEN_BITS = 24;
    localparam int CNT_MAX  = (FRAME_BITS > LEN_BITS) ? FRAME_BITS : LEN_BITS;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(2);
    localparam logic [CNT_W-1:0] LEN_LAST   = CNT_W'(LEN_BITS - 1);
    localparam logic [CNT_W-1:0] LSTOP_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] FSTOP_LAST = CNT_W'(2);
    localparam logic [FA_W-1:0]  LAST_FA    = FA_W'(NUM_FRAMES - 1);
    localparam logic [3:0]       ONES_SAT   = 4'd8;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_SYNC   = 4'd1;
    localparam logic [3:0] S_LEN    = 4'd2;
    localparam logic [3:0] S_LSTOP  = 4'd3;
    localparam logic [3:0] S_FSTART = 4'd4;
    localparam logic [3:0] S_FDATA  = 4'd5;
    localparam logic [3:0] S_FSTOP  = 4'd6;
    localparam logic [3:0] S_DONE   = 4'd7;
    localparam logic [3:0] S_ERR    = 4'd8;

    logic [3:0]            state_q,     state_d;
    logic [3:0]            ones_q,      ones_d;
    logic [CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [FA_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic [FRAME_BITS-1:0] shift_q,     shift_d;
    logic [23:0]           len_q,       len_d;
    logic [FRAME_BITS-1:0] fdata_q,     fdata_d;
    logic [FA_W-1:0]       faddr_q,     faddr_d;
    logic                  fvalid_q,    fvalid_d;
    logic                  done_q,      done_d;
    logic                  err_q,       err_d;
    logic                  stop_bad;
    logic                  sync_exp;

`ifdef XC20XX_CFG_STOPCHK_EN
    assign stop_bad = ~DIN;
`else
    assign stop_bad = 1'b0;
`endif

    // The three sync bits after the ones run are 0,1,0; only the middle one is a 1.
    assign sync_exp = (bit_cnt_q == CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        ones_d      = ones_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        shift_d     = shift_q;
        len_d       = len_q;
        fdata_d     = fdata_q;
        faddr_d     = faddr_q;
        fvalid_d    = 1'b0;
        done_d      = done_q;
        err_d       = err_q;

        if (DIN_VALID) begin
            case (state_q)
                S_IDLE: begin
                    if (DIN) begin
                        if (ones_q != ONES_SAT) begin
                            ones_d = ones_q + 4'd1;
                        end
                    end else if (ones_q == ONES_SAT) begin
                        state_d   = S_SYNC;
                        ones_d    = 4'd0;
                        bit_cnt_d = '0;
                    end else begin
                        ones_d = 4'd0;
                    end
                end

                S_SYNC: begin
                    if (DIN != sync_exp) begin
                        state_d   = S_IDLE;
                        ones_d    = 4'd0;
                        bit_cnt_d = '0;
                    end else if (bit_cnt_q == SYNC_LAST) begin
                        state_d   = S_LEN;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end

                S_LEN: begin
                    len_d = {len_q[22:0], DIN};
                    if (bit_cnt_q == LEN_LAST) begin
                        state_d   = S_LSTOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end

                S_LSTOP: begin
                    if (stop_bad) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (bit_cnt_q == LSTOP_LAST) begin
                        state_d   = S_FSTART;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end

                S_FSTART: begin
                    if (DIN) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = S_FDATA;
                        bit_cnt_d = '0;
                    end
                end

                S_FDATA: begin
                    shift_d = {shift_q[FRAME_BITS-2:0], DIN};
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d   = S_FSTOP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end

                S_FSTOP: begin
                    if (stop_bad) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else if (bit_cnt_q == FSTOP_LAST) begin
                        // Frame is published only once all stop bits are in, so a bad stop never pulses.
                        fdata_d   = shift_q;
                        faddr_d   = frame_cnt_q;
                        fvalid_d  = 1'b1;
                        bit_cnt_d = '0;
                        if (frame_cnt_q == LAST_FA) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d     = S_FSTART;
                            frame_cnt_d = frame_cnt_q + FA_W'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end

                S_DONE, S_ERR: begin
                    state_d = state_q;
                end

                default: begin
                    state_d = S_IDLE;
                    ones_d  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge K or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            ones_q      <= 4'd0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            shift_q     <= '0;
            len_q       <= '0;
            fdata_q     <= '0;
            faddr_q     <= '0;
            fvalid_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ones_q      <= ones_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            shift_q     <= shift_d;
            len_q       <= len_d;
            fdata_q     <= fdata_d;
            faddr_q     <= faddr_d;
            fvalid_q    <= fvalid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign FRAME_DATA  = fdata_q;
    assign FRAME_ADDR  = faddr_q;
    assign FRAME_VALID = fvalid_q;
    assign LEN_COUNT   = len_q;
    assign DONE        = done_q;
    assign ERROR       = err_q;
    assign STATE_DBG   = state_q;

endmodule

// File: tb/tb_xc20xx_cfg_loader.sv
// Bench for xc20xx_cfg_loader: bitstreams are assembled from their field layout, and expected frames are
// queued as the last stop bit of each is issued; a monitor pops them whenever FRAME_VALID is seen.
module tb_xc20xx_cfg_loader;
    localparam int FB  = 4;
    localparam int NF  = 2;
    localparam int FAW = 8;
    localparam int EW  = 1 + FAW + FB;

    logic           K = 1'b0;
    logic           RST_N = 1'b0;
    logic           DIN = 1'b0;
    logic           DIN_VALID = 1'b0;
    logic [FB-1:0]  FRAME_DATA;
    logic [FAW-1:0] FRAME_ADDR;
    logic           FRAME_VALID;
    logic [23:0]    LEN_COUNT;
    logic           DONE;
    logic           ERROR;
    logic [3:0]     STATE_DBG;

    always #5 K = ~K;

    xc20xx_cfg_loader #(.FRAME_BITS(FB), .NUM_FRAMES(NF), .FA_W(FAW)) dut (
        .K(K), .RST_N(RST_N), .DIN(DIN), .DIN_VALID(DIN_VALID),
        .FRAME_DATA(FRAME_DATA), .FRAME_ADDR(FRAME_ADDR), .FRAME_VALID(FRAME_VALID),
        .LEN_COUNT(LEN_COUNT), .DONE(DONE), .ERROR(ERROR), .STATE_DBG(STATE_DBG)
    );

    // Scoreboard entries are {done, addr, data} as seen on a FRAME_VALID cycle.
    logic [EW-1:0]  exp_q[$];
    int             n_cmp = 0;
    int             n_mis = 0;
    bit             stream_q[$];
    int             mark_pos[$];
    logic [EW-1:0]  mark_val[$];
    logic [FB-1:0]  fdata [NF];
    bit             gaps = 1'b0;
    logic [23:0]    exp_len;
    bit             exp_done;
    bit             exp_err;
    logic [FB-1:0]  exp_fd;
    logic [FAW-1:0] exp_fa;
    logic [EW-1:0]  mon_e;
    int             cut;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) stream_q.push_back(v[i]);
    endtask

    // Lay out one bitstream and derive the outcome straight from its field structure.
    task automatic build(input int prefix, input int n_ones, input logic [23:0] len,
                         input int start_err, input int stop_err);
        logic [2:0] stp;
        stream_q.delete();
        mark_pos.delete();
        mark_val.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_len  = len;
        exp_fd   = '0;
        exp_fa   = '0;
        if (prefix == 1) push_bits(32'b111_1111_0010, 11);
        if (prefix == 2) push_bits(32'b1111_1111_0011, 12);
        for (int i = 0; i < n_ones; i++) stream_q.push_back(1'b1);
        push_bits(32'b0010, 4);
        push_bits({8'h00, len}, 24);
`ifdef XC20XX_CFG_STOPCHK_EN
        push_bits(32'hF, 4);
`else
        push_bits($urandom_range(0, 15), 4);
`endif
        for (int i = 0; i < NF; i++) begin
            if (i == start_err) begin
                stream_q.push_back(1'b1);
                exp_err = 1'b1;
                break;
            end
            stream_q.push_back(1'b0);
            push_bits({28'd0, fdata[i]}, FB);
`ifdef XC20XX_CFG_STOPCHK_EN
            stp = (i == stop_err) ? 3'b101 : 3'b111;
`else
            stp = (i == stop_err) ? 3'b101 : 3'($urandom_range(0, 7));
`endif
            push_bits({29'd0, stp}, 3);
`ifdef XC20XX_CFG_STOPCHK_EN
            if (i == stop_err) begin
                exp_err = 1'b1;
                break;
            end
`endif
            mark_pos.push_back(stream_q.size() - 1);
            mark_val.push_back({(i == NF - 1), FAW'(i), fdata[i]});
            exp_fd = fdata[i];
            exp_fa = FAW'(i);
            if (i == NF - 1) exp_done = 1'b1;
        end
        push_bits($urandom, 8);
    endtask

    task automatic send_bit(input bit b);
        DIN       = b;
        DIN_VALID = 1'b1;
        @(posedge K);
        #1;
        DIN_VALID = 1'b0;
        if (gaps) begin
            DIN = 1'($urandom);
            @(posedge K);
            #1;
        end
    endtask

    task automatic do_reset(input string tag);
        #2 RST_N = 1'b0;
        #1;
        check({tag, "_data"},  FRAME_DATA,  0);
        check({tag, "_addr"},  FRAME_ADDR,  0);
        check({tag, "_valid"}, FRAME_VALID, 0);
        check({tag, "_len"},   LEN_COUNT,   0);
        check({tag, "_done"},  DONE,        0);
        check({tag, "_error"}, ERROR,       0);
        exp_q.delete();
        @(negedge K);
        @(negedge K);
        RST_N = 1'b1;
        @(posedge K);
        #1;
    endtask

    task automatic run(input int cut_at);
        do_reset("rst");
        for (int j = 0; j < stream_q.size(); j++) begin
            if (j == cut_at) begin
                check("pending_at_cut", exp_q.size(), 0);
                do_reset("midrst");
                return;
            end
            if (mark_pos.size() > 0 && mark_pos[0] == j) begin
                exp_q.push_back(mark_val.pop_front());
                void'(mark_pos.pop_front());
            end
            send_bit(stream_q[j]);
        end
        repeat (3) @(posedge K);
        #1;
        check("done",       DONE,       exp_done);
        check("error",      ERROR,      exp_err);
        check("len_count",  LEN_COUNT,  exp_len);
        check("frame_data", FRAME_DATA, exp_fd);
        check("frame_addr", FRAME_ADDR, exp_fa);
        check("pending",    exp_q.size(), 0);
    endtask

    initial begin
        fork
            forever begin
                @(negedge K);
                if (RST_N && FRAME_VALID) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_mis++;
                        $display("FAIL unexpected_frame: got addr %0d data 0x%0h, expected no frame",
                                 FRAME_ADDR, FRAME_DATA);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("frame", {DONE, FRAME_ADDR, FRAME_DATA}, mon_e);
                    end
                end
            end
        join_none

        fdata[0] = 4'b1010;
        fdata[1] = 4'b0110;
        build(0, 8, 24'h000030, -1, -1);
        run(-1);
        build(1, 8, 24'h000030, -1, -1);
        run(-1);
        build(0, 8, 24'h000030, 0, -1);
        run(-1);
        build(0, 8, 24'h000030, -1, 0);
        run(-1);
        gaps = 1'b1;
        build(0, 8, 24'h000030, -1, -1);
        run(-1);
        gaps = 1'b0;
        build(0, 8, 24'h000030, -1, -1);
        cut = mark_pos[0] + 3;
        run(cut);
        build(0, 8, 24'h000030, -1, -1);
        run(-1);

        for (int r = 0; r < 24; r++) begin
            int kind;
            kind = $urandom_range(0, 3);
            gaps = 1'($urandom_range(0, 1));
            for (int f = 0; f < NF; f++) fdata[f] = FB'($urandom);
            build((kind == 3) ? $urandom_range(1, 2) : 0, $urandom_range(8, 12), 24'($urandom),
                  (kind == 1) ? $urandom_range(0, NF - 1) : -1,
                  (kind == 2) ? $urandom_range(0, NF - 1) : -1);
            run(-1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/xc20xx_cfg_loader.md
XC20XX_CFG_LOADER -- requirements
Module: xc20xx_cfg_loader

Interface
REQ-001 SHALL have parameter FRAME_BITS, default 46, data bits per configuration frame (excludes start and stop bits).
REQ-002 SHALL have parameter NUM_FRAMES, default 160, frames per bitstream.
REQ-003 SHALL have parameter FA_W, default 8, frame address width; FA_W SHALL be at least clog2(NUM_FRAMES).
REQ-004 SHALL have port K, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port DIN, input, 1 bit: serial bitstream bit, MSB first.
REQ-007 SHALL have port DIN_VALID, input, 1 bit: DIN is consumed only on edges where this is high.
REQ-008 SHALL have port FRAME_DATA, output, FRAME_BITS bits: last completed frame, first-received bit in MSB.
REQ-009 SHALL have port FRAME_ADDR, output, FA_W bits: index of FRAME_DATA, counted 0..NUM_FRAMES-1.
REQ-010 SHALL have port FRAME_VALID, output, 1 bit: one-cycle pulse, FRAME_DATA/FRAME_ADDR are valid.
REQ-011 SHALL have port LEN_COUNT, output, 24 bits: captured length count field.
REQ-012 SHALL have port DONE, output, 1 bit: sticky, all frames loaded.
REQ-013 SHALL have port ERROR, output, 1 bit: sticky, bitstream format violation.

Function
REQ-014 SHALL implement states IDLE, SYNC, LEN, LSTOP, FSTART, FDATA, FSTOP, DONE and ERR; a state advances only on a DIN_VALID-high edge.
REQ-015 IDLE SHALL count consecutive 1s (saturating at 8); on a 0 after at least 8 ones, go to SYNC; on a 0 after fewer than 8 ones, clear the count and stay in IDLE.
REQ-016 SYNC SHALL require exactly the bits 0,1,0 (completing preamble 0010), then go to LEN; any mismatch returns to IDLE with the ones count cleared (not ERR).
REQ-017 LEN SHALL shift 24 bits MSB first into LEN_COUNT, then go to LSTOP.
REQ-018 LSTOP SHALL consume 4 bits, then go to FSTART.
REQ-019 FSTART SHALL require DIN=0 and then go to FDATA; DIN=1 SHALL go to ERR.
REQ-020 FDATA SHALL shift FRAME_BITS bits into an internal shift register, then go to FSTOP.
REQ-021 FSTOP SHALL consume 3 bits; on the third bit it SHALL copy the shift register to FRAME_DATA, drive FRAME_ADDR with the frame counter, and pulse FRAME_VALID on the next cycle.
REQ-022 After the stop bits, SHALL increment the frame counter and go to FSTART; if the frame was index NUM_FRAMES-1, SHALL go to DONE instead.
REQ-023 DONE and ERR SHALL be absorbing; input is ignored until reset.
REQ-024 DONE output SHALL assert in the same cycle the last FRAME_VALID pulses; ERROR SHALL assert on entry to ERR.
REQ-025 FRAME_DATA and FRAME_ADDR SHALL hold until the next frame completes.
REQ-026 DIN_VALID low SHALL freeze all state, counters and outputs except FRAME_VALID, which SHALL return to 0.
REQ-027 LEN_COUNT SHALL be informational only and SHALL NOT gate termination.

Reset
REQ-028 RST_N low SHALL immediately force IDLE, clear all counters and shift registers, and drive FRAME_DATA=0, FRAME_ADDR=0, FRAME_VALID=0, LEN_COUNT=0, DONE=0, ERROR=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; loading restarts with preamble detection.

Configuration
REQ-030 With macro XC20XX_CFG_STOPCHK_EN defined, each LSTOP and FSTOP bit SHALL be required to be 1, and any 0 SHALL go to ERR without pulsing FRAME_VALID for that frame.
REQ-031 Without XC20XX_CFG_STOPCHK_EN, LSTOP/FSTOP bit values SHALL be ignored.

Verification (FRAME_BITS=4, NUM_FRAMES=2 unless stated)
REQ-032 Stream 11111111 0010, len 0x000030, 1111, frames 0 1010 111 and 0 0110 111 -> FRAME_VALID twice; (ADDR 0, DATA 1010), then (ADDR 1, DATA 0110); DONE=1; LEN_COUNT=0x000030; ERROR=0.
REQ-033 Stream 1111111 0010 (7 ones) followed by a valid stream -> only the second preamble locks; same outputs as REQ-032.
REQ-034 Valid header, then frame start bit 1 -> ERROR=1, no FRAME_VALID, further bits ignored.
REQ-035 XC20XX_CFG_STOPCHK_EN defined, frame 0 stop bits 101 -> ERROR=1, no FRAME_VALID; macro undefined -> frame accepted, DATA per REQ-032.
REQ-036 DIN_VALID toggled low every other cycle during REQ-032 stream -> identical results; RST_N pulsed low mid frame 1 -> all outputs 0 immediately; a replayed full stream yields REQ-032 results.
